decode_stage_n: RTL and testbench

Registered, parametrised N-lane instruction decode stage for the superscalar RV32I core, placed between fetch and rename/issue. Each cycle it accepts a bundle of up to LANES instructions over a valid/ready handshake. It splits each instruction into fields, generates sign-extended immediates, classifies it against the supported subset, and flags intra-bundle RAW dependencies. Output is fully registered behind a 2-entry skid buffer, so backpressure never forms a combinational ready path.

---
 rtl/decode_pkg.sv | 62 ++++++
 rtl/decode_lane.sv | 55 +++++
 rtl/decode_stage_n.sv | 160 ++++++++++++++++
 tb/tb_decode_stage_n.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode constants, class enum, lane result structs and immediate helper
package decode_pkg;

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRA     = 3'b101;
    localparam logic [2:0] F3_ANDI    = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU_R   = 3'd1,
        CLS_ALU_I   = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_ILLEGAL = 3'd7
    } class_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Everything that leaves the stage for one lane
    typedef struct packed {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        class_t      cls;
        logic        rd_we;
    } lane_out_t;

    // Register-read flags are only needed for the in-bundle dependency check
    typedef struct packed {
        lane_out_t o;
        logic      reads_rs1;
        logic      reads_rs2;
    } lane_dec_t;

    function automatic logic [31:0] imm_gen(input class_t cls, input logic [31:0] instr);
        case (cls)
            CLS_ALU_I, CLS_LOAD: imm_gen = {{20{instr[31]}}, instr[31:20]};
            CLS_STORE:           imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            default:             imm_gen = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/decode_lane.sv
// rtl/decode_lane.sv - combinational single-lane field split, classification and immediate generation
module decode_lane
    import decode_pkg::*;
(
    input  logic        lane_en,
    input  logic [31:0] instr,
    output lane_dec_t   dec
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    class_t     cls;

    assign opcode = instr[6:0];
    assign func3  = instr[14:12];
    assign func7  = instr[31:25];

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ALU_R: begin
                if ((func7 == F7_BASE && (func3 == F3_ADD_SUB || func3 == F3_XOR)) ||
                    (func7 == F7_ALT  && (func3 == F3_ADD_SUB || func3 == F3_SRA)))
                    cls = CLS_ALU_R;
            end
            OP_ALU_I: if (func3 == F3_ADD_SUB || func3 == F3_ANDI) cls = CLS_ALU_I;
            OP_LOAD:  if (func3 == F3_WORD) cls = CLS_LOAD;
            OP_STORE: if (func3 == F3_WORD) cls = CLS_STORE;
            default:  cls = CLS_ILLEGAL;
        endcase
    end

    // A disabled lane decodes to all zeros, including the raw instruction
    always_comb begin
        dec = '0;
        if (lane_en) begin
            dec.o.instr  = instr;
            dec.o.opcode = opcode;
            dec.o.func3  = func3;
            dec.o.func7  = func7;
            dec.o.rs1    = instr[19:15];
            dec.o.rs2    = instr[24:20];
            dec.o.rd     = instr[11:7];
            dec.o.imm    = imm_gen(cls, instr);
            dec.o.cls    = cls;
            dec.o.rd_we  = (cls == CLS_ALU_R || cls == CLS_ALU_I || cls == CLS_LOAD) &&
                           (instr[11:7] != 5'd0);
            dec.reads_rs1 = (cls == CLS_ALU_R || cls == CLS_ALU_I ||
                             cls == CLS_LOAD  || cls == CLS_STORE);
            dec.reads_rs2 = (cls == CLS_ALU_R || cls == CLS_STORE);
        end
    end

endmodule

// File: rtl/decode_stage_n.sv
// rtl/decode_stage_n.sv - registered N-lane RV32I decode stage with RAW flags behind a 2-entry skid buffer
module decode_stage_n
    import decode_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES-1:0]     in_lane_en,
    input  logic [32*LANES-1:0]  in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out_lane_en,
    output logic [32*LANES-1:0]  out_instr,
    output logic [7*LANES-1:0]   out_opcode,
    output logic [3*LANES-1:0]   out_func3,
    output logic [7*LANES-1:0]   out_func7,
    output logic [5*LANES-1:0]   out_rs1,
    output logic [5*LANES-1:0]   out_rs2,
    output logic [5*LANES-1:0]   out_rd,
    output logic [32*LANES-1:0]  out_imm,
    output logic [3*LANES-1:0]   out_class,
    output logic [LANES-1:0]     out_rd_we,
    output logic [LANES-1:0]     out_dep
);

    lane_dec_t [LANES-1:0] dec;
    logic      [LANES-1:0] dep_c;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        decode_lane u_lane (
            .lane_en (in_lane_en[g]),
            .instr   (in_instr[32*g +: 32]),
            .dec     (dec[g])
        );
    end

    // Disabled lanes decode with rd_we=0 and no reads, so they never create or receive a dependency
    always_comb begin
        dep_c = '0;
        for (int j = 1; j < LANES; j++) begin
            for (int i = 0; i < j; i++) begin
                if (dec[i].o.rd_we &&
                    ((dec[j].reads_rs1 && dec[i].o.rd == dec[j].o.rs1) ||
                     (dec[j].reads_rs2 && dec[i].o.rd == dec[j].o.rs2)))
                    dep_c[j] = 1'b1;
            end
        end
    end

    buf_state_t state, next_state;
    logic       in_ready_q;
    logic       in_fire, out_fire, main_valid;
    logic       ld_main_in, ld_main_skid, ld_skid;

    lane_out_t [LANES-1:0] main_q, skid_q;
    logic      [LANES-1:0] main_en, skid_en, main_dep, skid_dep;

    assign main_valid = (state != BUF_EMPTY);
    assign in_fire    = in_valid & in_ready_q;
    assign out_fire   = main_valid & out_ready;

    always_comb begin
        next_state   = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            next_state = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        next_state = BUF_ONE;
                        ld_main_in = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (out_fire) begin
                        next_state = BUF_EMPTY;
                    end else if (in_fire) begin
                        next_state = BUF_FULL;
                        ld_skid    = 1'b1;
                    end
                end
                BUF_FULL: begin
                    if (out_fire) begin
                        next_state   = BUF_ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: next_state = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != BUF_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            main_en  <= '0;
            main_dep <= '0;
            skid_q   <= '0;
            skid_en  <= '0;
            skid_dep <= '0;
        end else if (flush) begin
            main_q   <= '0;
            main_en  <= '0;
            main_dep <= '0;
        end else begin
            if (ld_main_in) begin
                for (int i = 0; i < LANES; i++) main_q[i] <= dec[i].o;
                main_en  <= in_lane_en;
                main_dep <= dep_c;
            end else if (ld_main_skid) begin
                main_q   <= skid_q;
                main_en  <= skid_en;
                main_dep <= skid_dep;
            end
            if (ld_skid) begin
                for (int i = 0; i < LANES; i++) skid_q[i] <= dec[i].o;
                skid_en  <= in_lane_en;
                skid_dep <= dep_c;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid;
    assign out_lane_en = main_en;
    assign out_dep     = main_dep;

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign out_instr [32*g +: 32] = main_q[g].instr;
        assign out_opcode[7*g  +: 7]  = main_q[g].opcode;
        assign out_func3 [3*g  +: 3]  = main_q[g].func3;
        assign out_func7 [7*g  +: 7]  = main_q[g].func7;
        assign out_rs1   [5*g  +: 5]  = main_q[g].rs1;
        assign out_rs2   [5*g  +: 5]  = main_q[g].rs2;
        assign out_rd    [5*g  +: 5]  = main_q[g].rd;
        assign out_imm   [32*g +: 32] = main_q[g].imm;
        assign out_class [3*g  +: 3]  = main_q[g].cls;
        assign out_rd_we [g]          = main_q[g].rd_we;
    end

endmodule

// File: tb/tb_decode_stage_n.sv
// tb/tb_decode_stage_n.sv - directed scoreboard bench for the two-lane decode stage
module tb_decode_stage_n;

    localparam int LANES = 2;

    logic                clk = 1'b0;
    logic                rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LANES-1:0]    in_lane_en, out_lane_en, out_rd_we, out_dep;
    logic [32*LANES-1:0] in_instr, out_instr, out_imm;
    logic [7*LANES-1:0]  out_opcode, out_func7;
    logic [3*LANES-1:0]  out_func3, out_class;
    logic [5*LANES-1:0]  out_rs1, out_rs2, out_rd;

    always #5 clk = ~clk;

    decode_stage_n #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
        .out_instr(out_instr), .out_opcode(out_opcode), .out_func3(out_func3),
        .out_func7(out_func7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_class(out_class), .out_rd_we(out_rd_we), .out_dep(out_dep)
    );

    typedef struct packed {
        logic [1:0]  en;
        logic [63:0] raw;
        logic [5:0]  cls;
        logic [9:0]  rd;
        logic [1:0]  we;
        logic [63:0] imm;
        logic [1:0]  dep;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [1:0] en, input logic [31:0] r0, input logic [31:0] r1,
                                input logic [2:0] c0, input logic [2:0] c1,
                                input logic [4:0] d0, input logic [4:0] d1, input logic [1:0] we,
                                input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] dep);
        exp_t e;
        e.en = en; e.raw = {r1, r0}; e.cls = {c1, c0}; e.rd = {d1, d0};
        e.we = we; e.imm = {i1, i0}; e.dep = dep;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input exp_t e, input logic v);
        cur        = e;
        in_valid   = v;
        in_lane_en = e.en;
        in_instr   = e.raw;
    endtask

    task automatic step(output logic fired);
        exp_t        e;
        logic [63:0] ei;
        fired = in_valid && in_ready && !flush;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e  = q.pop_front();
                ei = {e.en[1] ? e.raw[63:32] : 32'd0, e.en[0] ? e.raw[31:0] : 32'd0};
                chk("lane_en", 64'(out_lane_en), 64'(e.en));
                chk("instr",   out_instr,        ei);
                chk("class",   64'(out_class),   64'(e.cls));
                chk("rd",      64'(out_rd),      64'(e.rd));
                chk("rd_we",   64'(out_rd_we),   64'(e.we));
                chk("imm",     out_imm,          e.imm);
                chk("dep",     64'(out_dep),     64'(e.dep));
            end
        end
        if (fired) q.push_back(cur);
        @(posedge clk);
        @(negedge clk);
    endtask

    exp_t b_add, b_sw, b_ill, b_x;
    exp_t bp[4];
    logic f;
    int   acc;
    logic seen_stall;

    initial begin
        b_add = mk(2'b11, 32'h002081B3, 32'h404182B3, 3'd1, 3'd1, 5'd3, 5'd5, 2'b11, 32'd0, 32'd0, 2'b10);
        b_sw  = mk(2'b11, 32'hFE20AE23, 32'h00802303, 3'd4, 3'd3, 5'd28, 5'd6, 2'b10,
                   32'hFFFFFFFC, 32'h00000008, 2'b00);
        b_ill = mk(2'b01, 32'hFFFFFFFF, 32'h002081B3, 3'd7, 3'd0, 5'd31, 5'd0, 2'b00, 32'd0, 32'd0, 2'b00);
        bp[0] = mk(2'b11, 32'h00500093, 32'hFFF0F113, 3'd2, 3'd2, 5'd1, 5'd2, 2'b11,
                   32'd5, 32'hFFFFFFFF, 2'b10);
        bp[1] = mk(2'b11, 32'h0020C033, 32'h400053B3, 3'd1, 3'd1, 5'd0, 5'd7, 2'b10, 32'd0, 32'd0, 2'b00);
        bp[2] = mk(2'b11, 32'h400053B3, 32'h000011B3, 3'd1, 3'd7, 5'd7, 5'd3, 2'b01, 32'd0, 32'd0, 2'b00);
        bp[3] = mk(2'b11, 32'h00802303, 32'h00632023, 3'd3, 3'd4, 5'd6, 5'd0, 2'b01, 32'd8, 32'd0, 2'b10);
        b_x   = mk(2'b00, 32'h12345678, 32'h9ABCDEF0, 3'd0, 3'd0, 5'd0, 5'd0, 2'b00, 32'd0, 32'd0, 2'b00);

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(b_x, 1'b0);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_instr",     out_instr,      64'd0);
        chk("reset_class",     64'(out_class), 64'd0);
        chk("reset_imm",       out_imm,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed bundles at full throughput
        drive(b_add, 1'b1); step(f);
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        drive(b_sw, 1'b1);  step(f);
        drive(b_ill, 1'b1); step(f);
        chk("dis_opcode", 64'(out_opcode[13:7]), 64'd0);
        chk("dis_func3",  64'(out_func3[5:3]),   64'd0);
        chk("dis_func7",  64'(out_func7[13:7]),  64'd0);
        chk("dis_rs1",    64'(out_rs1[9:5]),     64'd0);
        chk("dis_rs2",    64'(out_rs2[9:5]),     64'd0);
        chk("ill_opcode", 64'(out_opcode[6:0]),  64'h7F);
        drive(b_x, 1'b1);   step(f);
        drive(b_x, 1'b0);   step(f);
        step(f);
        chk("directed_drained", 64'(q.size()), 64'd0);

        // Backpressure: consumer stalls for the first three cycles
        acc = 0; seen_stall = 1'b0;
        for (int cyc = 0; cyc < 40 && (acc < 4 || q.size() != 0); cyc++) begin
            out_ready = (cyc >= 3);
            if (acc < 4) drive(bp[acc], 1'b1); else drive(b_x, 1'b0);
            step(f);
            if (f) acc++;
            if (acc == 2 && !seen_stall) begin
                chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
                seen_stall = 1'b1;
            end
        end
        chk("bp_all_accepted", 64'(acc), 64'd4);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Flush while FULL with a simultaneous input bundle
        out_ready = 1'b0;
        drive(bp[0], 1'b1); step(f);
        drive(bp[1], 1'b1); step(f);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(bp[3], 1'b1); step(f);
        flush = 1'b0;
        q.delete();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        drive(b_x, 1'b0);
        for (int k = 0; k < 3; k++) step(f);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(bp[2], 1'b1); step(f);
        drive(bp[3], 1'b1); step(f);
        drive(b_x, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd1);
        chk("arst_instr",     out_instr,      64'd0);
        chk("arst_rd_we",     64'(out_rd_we), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drive(b_sw, 1'b1); step(f);
        chk("post_reset_latency", 64'(out_valid), 64'd1);
        drive(b_x, 1'b0);  step(f);
        step(f);
        chk("post_reset_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
